// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared helpers and defaults for the filt_* stream filters
package filt_pkg;

    // Default width of the pass/drop statistics counters
    localparam int FILT_W_CNT_DEFAULT = 16;

    // Widest selector field the mask lookup supports
    localparam int FILT_W_CTRL_MAX = 8;
    localparam int FILT_MASK_MAX_W = 2 ** FILT_W_CTRL_MAX;

    // True when the selection mask has the bit for this ctrl value set
    function automatic logic sel_hit(
        input logic [FILT_MASK_MAX_W-1:0] mask,
        input logic [FILT_W_CTRL_MAX-1:0] ctrl
    );
        return mask[ctrl];
    endfunction

endpackage

// File: rtl/filt_sat_cnt.sv
// rtl/filt_sat_cnt.sv - saturating event counter with synchronous clear
module filt_sat_cnt
    import filt_pkg::*;
#(
    parameter int W_CNT = FILT_W_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [W_CNT-1:0] cnt
);

    logic [W_CNT-1:0] cnt_q;
    logic [W_CNT-1:0] cnt_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/filt_mask.sv
// rtl/filt_mask.sv - mask-selected stream filter with eot merging; FILT_MASK_STATS_EN adds pass/drop counters
module filt_mask
    import filt_pkg::*;
#(
    parameter int                      W_DIN    = 16,
    parameter int                      W_CTRL   = 1,
    parameter int                      LVL      = 1,
    parameter logic [2**W_CTRL-1:0]    SEL_MASK = 'b01,
    parameter int                      W_CNT    = FILT_W_CNT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LVL+W_CTRL+W_DIN-1:0]   din_data,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [LVL+W_DIN-1:0]          dout_data,
    output logic                          dout_valid,
    input  logic                          dout_ready
`ifdef FILT_MASK_STATS_EN
    ,
    input  logic                          clr_stats,
    output logic [W_CNT-1:0]              cnt_pass,
    output logic [W_CNT-1:0]              cnt_drop
`endif
);

    typedef struct packed {
        logic [LVL-1:0]    eot;
        logic [W_CTRL-1:0] ctrl;
        logic [W_DIN-1:0]  data;
    } din_t;

    typedef struct packed {
        logic [LVL-1:0]   eot;
        logic [W_DIN-1:0] data;
    } dout_t;

    din_t  din_s;
    dout_t dout_s;

    // One-entry hold: the last selected item not yet emitted
    logic             hold_v_q,    hold_v_d;
    logic [W_DIN-1:0] hold_data_q, hold_data_d;
    logic [LVL-1:0]   hold_eot_q,  hold_eot_d;

    logic sel;
    logic e0;
    logic hs;
    logic load;
    logic merge;
    logic empty_drop;
    logic plain_drop;

    assign din_s = din_data;
    assign sel   = sel_hit(FILT_MASK_MAX_W'(SEL_MASK), FILT_W_CTRL_MAX'(din_s.ctrl));
    assign e0    = din_s.eot[0];

    // The held item goes out only once a selected successor shows up or it carries its own end;
    // dout_ready never feeds back into dout_valid
    assign dout_valid = hold_v_q && ((din_valid && sel) || hold_eot_q[0]);
    assign hs         = dout_valid && dout_ready;

    assign dout_s.eot  = hold_eot_q;
    assign dout_s.data = hold_data_q;
    assign dout_data   = dout_s;

    assign load       = din_valid && sel && (!hold_v_q || hs);
    assign merge      = din_valid && !sel && e0 && hold_v_q && !hold_eot_q[0];
    // An end with nothing selected in front of it is swallowed; if the held item already
    // closed its transaction, the end must wait until that item drains
    assign empty_drop = din_valid && !sel && e0 && (!hold_v_q || (hold_eot_q[0] && hs));
    assign plain_drop = din_valid && !sel && !e0;
    assign din_ready  = load || merge || empty_drop || plain_drop;

    // Hold update: a load overrides the drain of the previous item in the same cycle
    always_comb begin
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        hold_eot_d  = hold_eot_q;
        if (load) begin
            hold_v_d    = 1'b1;
            hold_data_d = din_s.data;
            hold_eot_d  = din_s.eot;
        end else if (hs) begin
            hold_v_d   = 1'b0;
            hold_eot_d = '0;
        end else if (merge) begin
            // OR keeps any lower-level ends the held item already carries
            hold_eot_d = hold_eot_q | din_s.eot;
        end
    end

    // Hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q    <= 1'b0;
            hold_data_q <= '0;
            hold_eot_q  <= '0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            hold_eot_q  <= hold_eot_d;
        end
    end

`ifdef FILT_MASK_STATS_EN
    filt_sat_cnt #(
        .W_CNT (W_CNT)
    ) u_cnt_pass (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (hs),
        .cnt (cnt_pass)
    );

    filt_sat_cnt #(
        .W_CNT (W_CNT)
    ) u_cnt_drop (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (merge || empty_drop || plain_drop),
        .cnt (cnt_drop)
    );
`else
    logic unused_w_cnt;
    assign unused_w_cnt = (W_CNT > 0);
`endif

endmodule

// File: tb/tb_filt_mask.sv
// tb/tb_filt_mask.sv - scoreboard bench for filt_mask with a transaction-level reference model
module tb_filt_mask;

    localparam int         W_DIN    = 16;
    localparam int         W_CTRL   = 2;
    localparam int         LVL      = 2;
    localparam int         W_CNT    = 2;
    localparam logic [3:0] SEL_MASK = 4'b0101;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [LVL+W_CTRL+W_DIN-1:0] din_data;
    logic                        din_valid;
    logic                        din_ready;
    logic [LVL+W_DIN-1:0]        dout_data;
    logic                        dout_valid;
    logic                        dout_ready;
`ifdef FILT_MASK_STATS_EN
    logic                        clr_stats;
    logic [W_CNT-1:0]            cnt_pass;
    logic [W_CNT-1:0]            cnt_drop;
`endif

    filt_mask #(
        .W_DIN    (W_DIN),
        .W_CTRL   (W_CTRL),
        .LVL      (LVL),
        .SEL_MASK (SEL_MASK),
        .W_CNT    (W_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef FILT_MASK_STATS_EN
        ,
        .clr_stats  (clr_stats),
        .cnt_pass   (cnt_pass),
        .cnt_drop   (cnt_drop)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected output items {eot, data}, in order
    logic [LVL+W_DIN-1:0] exp_q[$];
    // Last selected item of the open transaction: final only once we know
    // whether the transaction's closing drop merges its end onto it
    logic                 pend_v = 1'b0;
    logic [LVL+W_DIN-1:0] pend;

    int   ready_mode = 0;
    logic rdy_force  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model, fed with each input item in stream order
    task automatic model_issue(input logic [1:0] c, input logic [1:0] e, input logic [15:0] d);
        if (SEL_MASK[c]) begin
            if (pend_v) exp_q.push_back(pend);
            if (e[0]) begin
                exp_q.push_back({e, d});
                pend_v = 1'b0;
            end else begin
                pend   = {e, d};
                pend_v = 1'b1;
            end
        end else if (e[0]) begin
            if (pend_v) begin
                exp_q.push_back({pend[17:16] | e, pend[15:0]});
                pend_v = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [1:0] e, input logic [15:0] d, output int waited);
        model_issue(c, e, d);
        din_data  = {e, c, d};
        din_valid = 1'b1;
        waited    = 0;
        while (1) begin
            @(negedge clk);
            if (din_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: item %0h never accepted", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pend_v = 1'b0;
    endtask

    // Output ready: forced value for directed phases, random for the soak
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode != 0) dout_ready = ($urandom_range(0, 3) != 0);
            else                 dout_ready = rdy_force;
        end
    end

    // Monitor: every output handshake pops one expected item
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h, expected no output", dout_data);
            end else begin
                logic [LVL+W_DIN-1:0] e;
                e = exp_q.pop_front();
                if (dout_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %0h, expected %0h", dout_data, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int budget;
        logic [1:0] c;
        logic [1:0] e;

        rst       = 1'b1;
        din_valid = 1'b0;
        din_data  = '0;
`ifdef FILT_MASK_STATS_EN
        clr_stats = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_din_ready", din_ready, 0);
`ifdef FILT_MASK_STATS_EN
        chk("rst_cnt_pass", cnt_pass, 0);
        chk("rst_cnt_drop", cnt_drop, 0);
`endif
        step();
        rst = 1'b0;
        step();

        // Selected stream, back to back
        send(2'd0, 2'b00, 16'd1, w); chk("sel_stall_1", w, 0);
        send(2'd2, 2'b00, 16'd2, w); chk("sel_stall_2", w, 0);
        send(2'd0, 2'b01, 16'd3, w); chk("sel_stall_3", w, 0);
        @(negedge clk);
        chk("sel_eot_latency", dout_valid, 1);
        step();

        // Trailing drop merges its eot onto the held item
        send(2'd0, 2'b00, 16'd5, w);
        send(2'd1, 2'b11, 16'd6, w);
        @(negedge clk);
        chk("merge_latency", dout_valid, 1);
        step();

        // Transaction with nothing selected
        send(2'd1, 2'b00, 16'h10, w); chk("empty_ready_1", w, 0);
        send(2'd3, 2'b01, 16'h11, w); chk("empty_ready_2", w, 0);
        @(negedge clk);
        chk("empty_no_out", dout_valid, 0);
        step();
        send(2'd0, 2'b00, 16'd7, w);
        send(2'd0, 2'b01, 16'd8, w);
        step();
        step();

        // Backpressure: held item with eot, unselected eot waiting behind it
        rdy_force = 1'b0;
        step();
        send(2'd0, 2'b01, 16'd9, w);
        model_issue(2'd1, 2'b01, 16'h20);
        din_data  = {2'b01, 2'd1, 16'h20};
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_din_stall", din_ready, 0);
            chk("bp_dout_valid", dout_valid, 1);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        chk("bp_release_din", din_ready, 1);
        chk("bp_release_dout", dout_valid, 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(negedge clk);
        chk("bp_eot_dropped", dout_valid, 0);
        step();

        // Reset with a held item
        send(2'd0, 2'b00, 16'h55, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        pend_v = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", dout_valid, 0);
        chk("rst_mid_data", dout_data, 0);
        step();
        send(2'd0, 2'b01, 16'h66, w);
        step();
        step();

        // Random soak with random output backpressure
        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            c = 2'($urandom_range(0, 3));
            e = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0)};
            send(c, e, 16'($urandom), w);
        end
        send(2'd0, 2'b01, 16'hffff, w);
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            step();
            budget++;
        end
        chk("soak_drained", exp_q.size(), 0);
        ready_mode = 0;
        rdy_force  = 1'b1;
        step();
        step();

`ifdef FILT_MASK_STATS_EN
        do_reset();
        step();
        for (int k = 0; k < 5; k++) send(2'd0, 2'b01, 16'(k + 100), w);
        send(2'd1, 2'b00, 16'h31, w);
        send(2'd3, 2'b10, 16'h32, w);
        step();
        step();
        @(negedge clk);
        chk("stats_pass_sat", cnt_pass, 3);
        chk("stats_drop", cnt_drop, 2);
        step();
        send(2'd0, 2'b01, 16'h77, w);
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        @(negedge clk);
        chk("stats_clr_pass", cnt_pass, 0);
        chk("stats_clr_drop", cnt_drop, 0);
        step();
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
